pipe_adder: RTL



---
 rtl/alu_pkg.sv | 19 +
 rtl/pipe_adder_slice.sv | 17 +
 rtl/pipe_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default add/sub datapath geometry and the op encoding
// used by both the pipelined adder and the execute stage.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    // Width of one carry slice; width must be a multiple of stages.
    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One carry slice of the pipelined adder: a CW-bit add with carry in and out.
module pipe_adder_slice #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o
);

    logic [CW:0] total;

    assign total      = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
    assign {c_o, s_o} = total;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor; stage k resolves carry slice k.
// Handshake: a beat moves on a rising edge when valid && ready on that side.
module pipe_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned STAGES = ALU_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW   = slice_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    logic                   sub_op;
    logic [STAGES-1:0]      v_q, en;
    logic [WIDTH-1:0]       a_q [STAGES];
    logic [WIDTH-1:0]       b_q [STAGES];
    logic [WIDTH-1:0]       s_q [STAGES];
    logic [STAGES-1:0]      c_q, sa_q, sb_q;

    logic [STAGES-1:0]      v_in, c_in, sa_in, sb_in;
    logic [WIDTH-1:0]       a_in [STAGES];
    logic [WIDTH-1:0]       b_in [STAGES];
    logic [WIDTH-1:0]       s_in [STAGES];
    logic [WIDTH-1:0]       s_d  [STAGES];
    logic [STAGES-1:0][CW-1:0] sl_sum;
    logic [STAGES-1:0]      sl_co;

    assign sub_op = (addsub_op_e'(sub) == OP_SUB);

    // Stage 0 takes conditioned operands from the ports, stage k from stage k-1.
    always_comb begin
        v_in[0]  = in_valid;
        a_in[0]  = a;
        b_in[0]  = sub_op ? ~b : b;
        c_in[0]  = sub_op ? ~cin : cin;
        s_in[0]  = '0;
        sa_in[0] = a[WIDTH-1];
        sb_in[0] = b_in[0][WIDTH-1];
        for (int k = 1; k < int'(STAGES); k++) begin
            v_in[k]  = v_q[k-1];
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            c_in[k]  = c_q[k-1];
            s_in[k]  = s_q[k-1];
            sa_in[k] = sa_q[k-1];
            sb_in[k] = sb_q[k-1];
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_slice
        pipe_adder_slice #(.CW(CW)) u_slice (
            .a_i (a_in[g][g*CW +: CW]),
            .b_i (b_in[g][g*CW +: CW]),
            .c_i (c_in[g]),
            .s_o (sl_sum[g]),
            .c_o (sl_co[g])
        );
    end

    // Bubble-collapsing enables: a stage may load if it is empty or drains.
    always_comb begin
        en       = '0;
        en[LAST] = !v_q[LAST] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            s_d[k]               = s_in[k];
            s_d[k][k*CW +: CW]   = sl_sum[k];
        end
    end

    assign in_ready = en[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            sa_q <= '0;
            sb_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (en[k]) begin
                    v_q[k] <= v_in[k];
                end
                // Data only moves with a real beat, so idle outputs keep their last result.
                if (en[k] && v_in[k]) begin
                    a_q[k]  <= a_in[k];
                    b_q[k]  <= b_in[k];
                    s_q[k]  <= s_d[k];
                    c_q[k]  <= sl_co[k];
                    sa_q[k] <= sa_in[k];
                    sb_q[k] <= sb_in[k];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign overflow  = (sa_q[LAST] == sb_q[LAST]) && (s_q[LAST][WIDTH-1] != sa_q[LAST]);

endmodule
